// File: rtl/sd_dat_rx_deser.sv
// SD DAT0 block receiver: start-bit hunt, MSB-first byte deserialiser, CRC16 + end-bit check.
// Latency: we/byte_out 1 clk after the sample_en that captures a byte's LSB; done 1 clk after end-bit sample.
// No backpressure: paced only by sample_en. Optional CRC16 check under SD_CRC16_CHECK_EN.
module sd_dat_rx_deser #(
    parameter int BLK_BYTES = 512,
    parameter int TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       sd_dat,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] byte_out,
    output logic [1:0] byte_sel,
    output logic       we,
    output logic       word_done,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic       end_err,
    output logic       timeout
);

    localparam int BCW = $clog2(BLK_BYTES);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLK_BYTES - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT,
        DONE
    } state_t;

    state_t         state;
    logic [6:0]     shift_reg;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [3:0]     crc_cnt;
    logic [TW-1:0]  tmo_cnt;

`ifdef SD_CRC16_CHECK_EN
    logic [15:0] calc_crc;
    logic [15:0] rx_crc;
    logic [15:0] crc_next;
    logic        crc_err_r;

    // Serial CRC16-CCITT (x^16 + x^12 + x^5 + 1), one data bit per sample.
    assign crc_next = {calc_crc[14:0], 1'b0} ^ ({16{calc_crc[15] ^ sd_dat}} & 16'h1021);
    assign crc_err  = crc_err_r;
`else
    assign crc_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            crc_cnt   <= '0;
            tmo_cnt   <= '0;
            byte_out  <= '0;
            byte_sel  <= '0;
            we        <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            end_err   <= 1'b0;
            timeout   <= 1'b0;
`ifdef SD_CRC16_CHECK_EN
            calc_crc  <= '0;
            rx_crc    <= '0;
            crc_err_r <= 1'b0;
`endif
        end else begin
            we        <= 1'b0;
            word_done <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= WAIT_START;
                            busy      <= 1'b1;
                            end_err   <= 1'b0;
                            tmo_cnt   <= '0;
`ifdef SD_CRC16_CHECK_EN
                            crc_err_r <= 1'b0;
`endif
                        end
                    end
                    WAIT_START: begin
                        if (sample_en) begin
                            if (!sd_dat) begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                byte_cnt <= '0;
`ifdef SD_CRC16_CHECK_EN
                                calc_crc <= '0;
`endif
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                                if (tmo_cnt == TMO_LAST) begin
                                    timeout <= 1'b1;
                                    state   <= IDLE;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sample_en) begin
                            shift_reg <= {shift_reg[5:0], sd_dat};
                            bit_cnt   <= bit_cnt + 1'b1;
`ifdef SD_CRC16_CHECK_EN
                            calc_crc  <= crc_next;
`endif
                            if (bit_cnt == 3'd7) begin
                                byte_out  <= {shift_reg, sd_dat};
                                byte_sel  <= byte_cnt[1:0];
                                we        <= 1'b1;
                                word_done <= &byte_cnt[1:0];
                                byte_cnt  <= byte_cnt + 1'b1;
                                if (byte_cnt == LAST_BYTE) begin
                                    state   <= CRC;
                                    crc_cnt <= '0;
                                end
                            end
                        end
                    end
                    CRC: begin
                        if (sample_en) begin
`ifdef SD_CRC16_CHECK_EN
                            rx_crc  <= {rx_crc[14:0], sd_dat};
`endif
                            crc_cnt <= crc_cnt + 1'b1;
                            if (crc_cnt == 4'd15)
                                state <= END_BIT;
                        end
                    end
                    END_BIT: begin
                        if (sample_en) begin
                            end_err   <= ~sd_dat;
`ifdef SD_CRC16_CHECK_EN
                            crc_err_r <= (calc_crc != rx_crc);
`endif
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE: begin
                        // done is visible for exactly this one clk while still busy
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sd_dat_rx_deser.md
Name: sd_dat_rx_deser

Overview:
- Single-line (DAT0) SD read-data receiver that sits directly upstream of byte_en_reg.
- Hunts for the start bit and deserialises a block of BLK_BYTES bytes, MSB first.
- Each byte is presented on byte_out with a byte_sel lane index and a one-cycle we pulse, so byte_en_reg assembles 32-bit words.
- Then consumes the 16-bit CRC and the end bit, and reports done or an error to sdc_controller.

Parameters:
- BLK_BYTES, 512, bytes per data block; must be a multiple of 4 and at least 4.
- TIMEOUT, 65535, maximum sample ticks spent waiting for the start bit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sample_en  in  1  one-clk strobe per SD clock period; sd_dat is sampled only when high
- sd_dat  in  1  DAT0 line, synchronised externally
- start  in  1  arm the receiver; honoured only in IDLE
- abort  in  1  synchronous return to IDLE; no done pulse
- byte_out  out  8  last assembled byte
- byte_sel  out  2  lane of byte_out within its 32-bit word (0 = first byte received)
- we  out  1  one-clk write strobe for byte_en_reg
- word_done  out  1  one-clk pulse coincident with the we of lane 3
- busy  out  1  high in every state except IDLE
- done  out  1  one-clk pulse at block end
- crc_err  out  1  valid with done; held until the next start
- end_err  out  1  valid with done; held until the next start
- timeout  out  1  one-clk pulse when the start bit is not seen in time

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All outputs 0, all counters 0, CRC register 0.
  - Reset mid-block discards the partial block; no done pulse.
- States: IDLE, WAIT_START, DATA, CRC, END_BIT, DONE.
- IDLE:
  - start=1 -> WAIT_START.
  - On that transition clear crc_err, end_err and the timeout counter.
- WAIT_START, on each sample_en:
  - sd_dat=0 -> DATA with bit_cnt=0, byte_cnt=0.
  - Otherwise increment tmo_cnt.
  - tmo_cnt reaching TIMEOUT -> pulse timeout, go to IDLE.
- DATA, on each sample_en:
  - Shift sd_dat into the LSB of the shift register and increment the 3-bit bit_cnt.
  - When the 8th bit is sampled (bit_cnt=7), on the next clk edge:
    - byte_out = the assembled byte.
    - byte_sel = byte_cnt[1:0].
    - we = 1 for exactly one clk.
    - word_done = 1 if byte_cnt[1:0]=3.
  - byte_cnt (width clog2(BLK_BYTES)) then increments.
  - After byte BLK_BYTES-1 -> CRC with a 4-bit crc_cnt=0.
- Latency: we asserts 1 clk after the sample_en cycle that captures the byte's LSB.
- CRC state:
  - Consume 16 samples MSB first into rx_crc.
  - After the 16th sample -> END_BIT.
- END_BIT:
  - Next sample: end_err = (sd_dat != 1).
  - Then -> DONE.
- DONE:
  - done = 1 for one clk.
  - crc_err and end_err are stable during that pulse.
  - Then -> IDLE.
- Strobe spacing: we and word_done never assert in two consecutive clks when sample_en spacing is ≥2; back-to-back sample_en is allowed.
- Simultaneous events and priority:
  - Priority is rst > abort > sample_en processing.
  - abort in any state -> IDLE next clk, no we/done.
  - A we already pending from the previous edge is still emitted.
  - start while busy is ignored.
- sample_en low: the state machine holds; counters freeze.

Optional Feature:
- Macro: SD_CRC16_CHECK_EN.
- Defined:
  - CRC16-CCITT (poly 0x1021, init 0x0000) is computed serially over every data bit in DATA, on the same sample_en.
  - At END_BIT, crc_err = (calc_crc != rx_crc).
- Undefined:
  - The CRC logic is absent.
  - The 16 CRC bits are still consumed.
  - crc_err is constant 0.
  - Timing is identical.

Test Plan:
- BLK_BYTES=4, sample_en every 2 clks, start; drive start bit 0, bytes 0xAB,0xCD,0x12,0x34, correct CRC, end bit 1 -> four we pulses with (byte_out,byte_sel) = (AB,0),(CD,1),(12,2),(34,3); word_done with the last; done=1, crc_err=0, end_err=0.
- Same block with rx CRC bit 0 flipped, SD_CRC16_CHECK_EN defined -> done=1, crc_err=1; with the macro undefined -> crc_err=0.
- Same block with end bit 0 -> done=1, end_err=1, all four we pulses still emitted.
- TIMEOUT=10, sd_dat held 1 after start -> timeout pulses after the 10th sample_en; busy=0 next clk; no we.
- BLK_BYTES=8, assert rst after byte 5 -> all outputs 0 immediately; restart with a fresh block -> byte_sel starts at 0.
- abort after byte 2 -> IDLE next clk, no done, no further we; start ignored while busy (pulse start in DATA) -> byte count unaffected.
